reset_key_filter: RTL and testbench

//  Front-end reset request stage: debounces the raw reset pushbutton and merges a software reset request.

---
 rtl/reset_key_filter.sv | 147 ++++++++++++++
 tb/tb_reset_key_filter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_key_filter.sv
// rtl/reset_key_filter.sv - debounced reset pushbutton and software reset merge into a fixed-width reset pulse
module reset_key_filter #(
  parameter int DEB_CYCLES   = 1000000,
  parameter int PULSE_CYCLES = 50000,
  parameter int LONG_CYCLES  = 100000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic KEY_N,
  input  logic SW_RESET_REQ,
  output logic SYS_RESET_N,
  output logic LONG_PRESS,
  output logic BUSY
);

  // One shared counter serves both debounce windows and the pulse width.
  localparam int CNT_MAX = (DEB_CYCLES > PULSE_CYCLES) ? DEB_CYCLES : PULSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int LW      = $clog2(LONG_CYCLES);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_ONE   = LW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PULSE    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          key_meta_q, key_meta_d;
  logic          key_s_q, key_s_d;
  logic          sys_reset_n_q, sys_reset_n_d;
  logic          long_press_q, long_press_d;
  logic          busy_q, busy_d;

  // State register: every flop, including the key synchronizer, takes its reset value here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= PULSE;
      cnt_q         <= '0;
      lcnt_q        <= '0;
      key_meta_q    <= 1'b1;
      key_s_q       <= 1'b1;
      sys_reset_n_q <= 1'b0;
      long_press_q  <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lcnt_q        <= lcnt_d;
      key_meta_q    <= key_meta_d;
      key_s_q       <= key_s_d;
      sys_reset_n_q <= sys_reset_n_d;
      long_press_q  <= long_press_d;
      busy_q        <= busy_d;
    end
  end

  // Two-flop synchronizer for the asynchronous pushbutton; only key_s_q feeds the FSM.
  always_comb begin
    key_meta_d = KEY_N;
    key_s_d    = key_meta_q;
  end

  // Next-state logic: debounce press, emit the pulse, then wait for a debounced release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      IDLE: begin
        lcnt_d = '0;
        if (SW_RESET_REQ) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else if (!key_s_q) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (SW_RESET_REQ) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          lcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (key_s_q) begin
          lcnt_d = '0;
          if (cnt_q == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
          // Saturate so a key held for hours cannot produce a second long-press pulse.
          if (lcnt_q != LONG_LAST) begin
            lcnt_d = lcnt_q + LCNT_ONE;
          end
        end
      end
      default: begin
        state_d = PULSE;
        cnt_d   = '0;
        lcnt_d  = '0;
      end
    endcase
  end

  // Output logic: outputs are decoded from next state so they register on the same edge as the state.
  always_comb begin
    sys_reset_n_d = (state_d != PULSE);
    busy_d        = (state_d != IDLE);
    long_press_d  = (state_q == HOLD) && (lcnt_d == LONG_LAST) && (lcnt_q != LONG_LAST);
  end

  assign SYS_RESET_N = sys_reset_n_q;
  assign LONG_PRESS  = long_press_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_reset_key_filter.sv
// tb/tb_reset_key_filter.sv - self-checking bench for reset_key_filter
module tb_reset_key_filter;

  localparam int D = 8;
  localparam int P = 4;
  localparam int L = 32;

  localparam int PH_IDLE  = 0;
  localparam int PH_DEB   = 1;
  localparam int PH_PULSE = 2;
  localparam int PH_HOLD  = 3;

  logic clk;
  logic rst;
  logic key_n;
  logic sw;
  logic sys_reset_n;
  logic long_press;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  reset_key_filter #(
    .DEB_CYCLES  (D),
    .PULSE_CYCLES(P),
    .LONG_CYCLES (L)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .KEY_N       (key_n),
    .SW_RESET_REQ(sw),
    .SYS_RESET_N (sys_reset_n),
    .LONG_PRESS  (long_press),
    .BUSY        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phases with timestamps and run lengths of the synchronized key.
  int   m_n = 0;
  int   m_ph = PH_PULSE;
  int   m_t0 = 0;
  int   m_rel_run = 0;
  int   m_press_run = 0;
  logic m_ks1 = 1'b1;
  logic m_ks2 = 1'b1;
  logic m_sys = 1'b0;
  logic m_long = 1'b0;
  logic m_busy = 1'b1;

  task automatic model_edge(input logic r, input logic k, input logic s);
    logic ks;
    ks = m_ks2;
    m_long = 1'b0;
    if (r) begin
      m_ph  = PH_PULSE;
      m_t0  = m_n;
      m_ks1 = 1'b1;
      m_ks2 = 1'b1;
    end else begin
      if (m_ph == PH_IDLE) begin
        if (s) begin m_ph = PH_PULSE; m_t0 = m_n; end
        else if (!ks) begin m_ph = PH_DEB; m_t0 = m_n; end
      end else if (m_ph == PH_DEB) begin
        if (s) begin m_ph = PH_PULSE; m_t0 = m_n; end
        else if (ks) m_ph = PH_IDLE;
        else if (m_n - m_t0 == D) begin m_ph = PH_PULSE; m_t0 = m_n; end
      end else if (m_ph == PH_PULSE) begin
        if (m_n - m_t0 == P) begin
          m_ph = PH_HOLD;
          m_rel_run = 0;
          m_press_run = 0;
        end
      end else begin
        if (ks) begin
          m_press_run = 0;
          m_rel_run++;
          if (m_rel_run == D) m_ph = PH_IDLE;
        end else begin
          m_rel_run = 0;
          m_press_run++;
          if (m_press_run == L - 1) m_long = 1'b1;
        end
      end
      m_ks2 = m_ks1;
      m_ks1 = k;
    end
    m_sys  = (m_ph != PH_PULSE);
    m_busy = (m_ph != PH_IDLE);
    m_n++;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic k, input logic s);
    @(negedge clk);
    rst   = r;
    key_n = k;
    sw    = s;
    @(posedge clk);
    model_edge(r, k, s);
    #1;
    check("model_sys_reset_n", sys_reset_n, m_sys);
    check("model_long_press", long_press, m_long);
    check("model_busy", busy, m_busy);
  endtask

  typedef struct {
    logic rst;
    logic key_n;
    logic sw;
    int   ncyc;
    logic e_sys;
    logic e_long;
    logic e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic k, input logic s, input int n,
                              input logic es, input logic el, input logic eb);
    vec_t v;
    v.rst = r; v.key_n = k; v.sw = s; v.ncyc = n;
    v.e_sys = es; v.e_long = el; v.e_busy = eb;
    tbl.push_back(v);
  endfunction

  // Key press from IDLE up to the first edge in HOLD.
  function automatic void add_press_to_hold();
    add(0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 7, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
  endfunction

  initial begin
    int rst_left;
    int key_left;
    logic key_lvl;
    logic r;
    logic s;

    rst   = 1'b1;
    key_n = 1'b1;
    sw    = 1'b0;

    // 1: reset with key released, pulse tail, release debounce back to IDLE
    add(1, 1, 0, 5, 0, 0, 1);
    add(0, 1, 0, 3, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 1, 0, 7, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0);
    // 2: short bounce rejected
    add(0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 2, 1, 0, 1);
    add(0, 1, 0, 2, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0);
    // 3: debounced press, exactly P-cycle pulse, release
    add_press_to_hold();
    add(0, 0, 0, 5, 1, 0, 1);
    add(0, 1, 0, 9, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0);
    // 4: long hold, single LONG_PRESS, no second pulse
    add_press_to_hold();
    add(0, 0, 0, 30, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 14, 1, 0, 1);
    add(0, 1, 0, 9, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0);
    // 5: software reset, repeats during PULSE and HOLD ignored
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 0, 2, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 1, 0, 6, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0);
    // 6: reset mid-HOLD with key held, then restart like test 1
    add_press_to_hold();
    add(0, 0, 0, 10, 1, 0, 1);
    add(1, 0, 0, 3, 0, 0, 1);
    add(1, 1, 0, 2, 0, 0, 1);
    add(0, 1, 0, 3, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 1, 0, 7, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        tick(tbl[i].rst, tbl[i].key_n, tbl[i].sw);
      end
      check($sformatf("vec%0d_sys_reset_n", i), sys_reset_n, tbl[i].e_sys);
      check($sformatf("vec%0d_long_press", i), long_press, tbl[i].e_long);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Randomized traffic: bouncy and long key runs, sparse software requests, rare resets.
    rst_left = 0;
    key_left = 0;
    key_lvl  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (key_left == 0) begin
        key_lvl  = ~key_lvl;
        key_left = (key_lvl == 1'b0) ? $urandom_range(1, 70) : $urandom_range(1, 20);
      end
      key_left--;
      if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 3);
      r = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      s = ($urandom_range(0, 29) == 0);
      tick(r, key_lvl, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
